// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg
// Shared types and constants for the write-back arbiter slice.
//   DEPTH_DEFAULT : default number of entries in each requester FIFO (2 or 4)
//   wb_entry_t    : one buffered write-back {is_vec, dir, data}
//   grant_e       : which FIFO head (if any) the arbiter takes this cycle
// ---------------------------------------------------------------------------
package wb_pkg;

    localparam int DEPTH_DEFAULT = 2;

    typedef struct packed {
        logic        is_vec;
        logic [2:0]  dir;
        logic [31:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_0    = 2'd1,
        GRANT_1    = 2'd2
    } grant_e;

endpackage

// File: rtl/wb_fifo.sv
// ---------------------------------------------------------------------------
// wb_fifo
// Small circular FIFO holding pending write-back entries for one requester.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (empties the FIFO)
//   i_push      : store i_data this edge (ignored while full)
//   i_data      : entry to store
//   i_pop       : drop the head entry this edge (ignored while empty)
//   o_full      : FIFO holds DEPTH entries (registered state only)
//   o_empty     : FIFO holds no entries
//   o_head      : oldest entry
//   o_valid     : per-slot occupancy, used for the pending-register decode
//   o_entries   : raw slot contents, qualified by o_valid
// ---------------------------------------------------------------------------
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_push,
    input  wb_entry_t               i_data,
    input  logic                    i_pop,
    output logic                    o_full,
    output logic                    o_empty,
    output wb_entry_t               o_head,
    output logic      [DEPTH-1:0]   o_valid,
    output wb_entry_t [DEPTH-1:0]   o_entries
);

    // DEPTH is a power of two, so pointers wrap naturally on overflow.
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE   = 1;
    localparam logic [CNT_W-1:0] CNT_ONE   = 1;
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);

    wb_entry_t [DEPTH-1:0] r_mem;
    logic [PTR_W-1:0]      r_wrPtr;
    logic [PTR_W-1:0]      r_rdPtr;
    logic [CNT_W-1:0]      r_count;

    logic w_doPush;
    logic w_doPop;

    assign o_full    = (r_count == CNT_FULL);
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rdPtr];
    assign o_entries = r_mem;

    assign w_doPush  = i_push && !o_full;
    assign w_doPop   = i_pop  && !o_empty;

    // Pointer and occupancy bookkeeping. A simultaneous push and pop moves
    // both pointers and leaves the count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + PTR_ONE;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + PTR_ONE;
            end
            if (w_doPush && !w_doPop) begin
                r_count <= r_count + CNT_ONE;
            end else if (!w_doPush && w_doPop) begin
                r_count <= r_count - CNT_ONE;
            end
        end
    end

    // Slot storage. Cleared on reset so stale data never shows up in the
    // pending decode even if a valid bit were ever misread.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem <= '0;
        end else if (w_doPush) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    // A slot is occupied when its distance from the read pointer (modulo
    // DEPTH) is smaller than the current count.
    always_comb begin
        logic [PTR_W-1:0] w_offset;
        o_valid  = '0;
        w_offset = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_offset   = PTR_W'(i) - r_rdPtr;
            o_valid[i] = ({1'b0, w_offset} < r_count);
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter
// Merges write-backs from the ALU path (requester 0) and the memory-load
// path (requester 1) onto the shared register-file write port. Each
// requester has its own FIFO; the heads are arbitrated round-robin and the
// winner is written out through registered strobes.
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   reqN_valid/ready           : push handshake for requester N
//   reqN_is_vec/dir/data       : entry content (scalar uses data[7:0])
//   reg_wrv / reg_wrs          : vector / scalar bank write strobes
//   i_dir_wr                   : shared write address
//   data_wrv / data_wrs        : vector (32b) / scalar (8b) write data
//   pend_vec / pend_sca        : per-register outstanding-write flags
// ---------------------------------------------------------------------------
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic        req0_is_vec,
    input  logic [2:0]  req0_dir,
    input  logic [31:0] req0_data,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic        req1_is_vec,
    input  logic [2:0]  req1_dir,
    input  logic [31:0] req1_data,
    output logic        reg_wrv,
    output logic        reg_wrs,
    output logic [2:0]  i_dir_wr,
    output logic [31:0] data_wrv,
    output logic [7:0]  data_wrs,
    output logic [7:0]  pend_vec,
    output logic [7:0]  pend_sca
);

    wb_entry_t              w_in0;
    wb_entry_t              w_in1;
    logic                   w_push0;
    logic                   w_push1;
    logic                   w_pop0;
    logic                   w_pop1;
    logic                   w_full0;
    logic                   w_full1;
    logic                   w_empty0;
    logic                   w_empty1;
    wb_entry_t              w_head0;
    wb_entry_t              w_head1;
    wb_entry_t              w_headSel;
    logic      [DEPTH-1:0]  w_valid0;
    logic      [DEPTH-1:0]  w_valid1;
    wb_entry_t [DEPTH-1:0]  w_entries0;
    wb_entry_t [DEPTH-1:0]  w_entries1;
    grant_e                 w_grant;
    logic      [7:0]        w_pendVec;
    logic      [7:0]        w_pendSca;

    logic                   r_lastGrant;
    logic                   r_regWrv;
    logic                   r_regWrs;
    logic      [2:0]        r_dirWr;
    logic      [31:0]       r_dataWrv;
    logic      [7:0]        r_dataWrs;

    assign w_in0 = {req0_is_vec, req0_dir, req0_data};
    assign w_in1 = {req1_is_vec, req1_dir, req1_data};

    // Ready comes only from the FIFO's registered count; a pop in the same
    // cycle does not reopen a full FIFO.
    assign req0_ready = !w_full0;
    assign req1_ready = !w_full1;
    assign w_push0    = req0_valid && req0_ready;
    assign w_push1    = req1_valid && req1_ready;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_push    (w_push0),
        .i_data    (w_in0),
        .i_pop     (w_pop0),
        .o_full    (w_full0),
        .o_empty   (w_empty0),
        .o_head    (w_head0),
        .o_valid   (w_valid0),
        .o_entries (w_entries0)
    );

    wb_fifo #(.DEPTH(DEPTH)) u_fifo1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_push    (w_push1),
        .i_data    (w_in1),
        .i_pop     (w_pop1),
        .o_full    (w_full1),
        .o_empty   (w_empty1),
        .o_head    (w_head1),
        .o_valid   (w_valid1),
        .o_entries (w_entries1)
    );

    // Round-robin choice between the two heads. A lone non-empty FIFO always
    // wins; on a tie the FIFO that did not win last time is taken.
    always_comb begin
        w_grant   = GRANT_NONE;
        w_headSel = w_head0;
        if (!w_empty0 && (w_empty1 || r_lastGrant)) begin
            w_grant   = GRANT_0;
            w_headSel = w_head0;
        end else if (!w_empty1) begin
            w_grant   = GRANT_1;
            w_headSel = w_head1;
        end
    end

    assign w_pop0 = (w_grant == GRANT_0);
    assign w_pop1 = (w_grant == GRANT_1);

    // Remember the last winner; reset favours requester 0 on the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lastGrant <= 1'b1;
        end else if (w_grant == GRANT_0) begin
            r_lastGrant <= 1'b0;
        end else if (w_grant == GRANT_1) begin
            r_lastGrant <= 1'b1;
        end
    end

    // Output register: the granted head is presented at the same edge it is
    // popped. Without a grant the strobes drop but address and data hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_regWrv  <= 1'b0;
            r_regWrs  <= 1'b0;
            r_dirWr   <= '0;
            r_dataWrv <= '0;
            r_dataWrs <= '0;
        end else if (w_grant != GRANT_NONE) begin
            r_regWrv  <= w_headSel.is_vec;
            r_regWrs  <= !w_headSel.is_vec;
            r_dirWr   <= w_headSel.dir;
            r_dataWrv <= w_headSel.data;
            r_dataWrs <= w_headSel.data[7:0];
        end else begin
            r_regWrv  <= 1'b0;
            r_regWrs  <= 1'b0;
        end
    end

    assign reg_wrv  = r_regWrv;
    assign reg_wrs  = r_regWrs;
    assign i_dir_wr = r_dirWr;
    assign data_wrv = r_dataWrv;
    assign data_wrs = r_dataWrs;

    // Pending decode: every buffered entry plus the one on the write port.
    // A register stays flagged through its strobe cycle and clears after.
    always_comb begin
        w_pendVec = '0;
        w_pendSca = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_valid0[i]) begin
                if (w_entries0[i].is_vec) begin
                    w_pendVec[w_entries0[i].dir] = 1'b1;
                end else begin
                    w_pendSca[w_entries0[i].dir] = 1'b1;
                end
            end
            if (w_valid1[i]) begin
                if (w_entries1[i].is_vec) begin
                    w_pendVec[w_entries1[i].dir] = 1'b1;
                end else begin
                    w_pendSca[w_entries1[i].dir] = 1'b1;
                end
            end
        end
        if (r_regWrv) begin
            w_pendVec[r_dirWr] = 1'b1;
        end
        if (r_regWrs) begin
            w_pendSca[r_dirWr] = 1'b1;
        end
    end

    assign pend_vec = w_pendVec;
    assign pend_sca = w_pendSca;

endmodule

// File: tb/tb_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_arbiter
// Drives both requesters with directed and random traffic and compares every
// output each cycle against a queue-based model of the two FIFOs and the
// round-robin write port.
// ---------------------------------------------------------------------------
module tb_wb_arbiter;

    localparam int TB_DEPTH = 2;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready, req0_is_vec;
    logic [2:0]  req0_dir;
    logic [31:0] req0_data;
    logic        req1_valid, req1_ready, req1_is_vec;
    logic [2:0]  req1_dir;
    logic [31:0] req1_data;
    logic        reg_wrv, reg_wrs;
    logic [2:0]  i_dir_wr;
    logic [31:0] data_wrv;
    logic [7:0]  data_wrs;
    logic [7:0]  pend_vec, pend_sca;

    wb_arbiter #(.DEPTH(TB_DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_is_vec (req0_is_vec),
        .req0_dir    (req0_dir),
        .req0_data   (req0_data),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_is_vec (req1_is_vec),
        .req1_dir    (req1_dir),
        .req1_data   (req1_data),
        .reg_wrv     (reg_wrv),
        .reg_wrs     (reg_wrs),
        .i_dir_wr    (i_dir_wr),
        .data_wrv    (data_wrv),
        .data_wrs    (data_wrs),
        .pend_vec    (pend_vec),
        .pend_sca    (pend_sca)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          isVec;
        int          dir;
        int unsigned data;
    } tbEntry_t;

    tbEntry_t    mq0[$];
    tbEntry_t    mq1[$];
    bit          mLast;
    bit          mWrv, mWrs;
    int          mDir;
    int unsigned mDataV;
    bit [7:0]    mDataS;

    int nChecks = 0;
    int nFails  = 0;

    // Single comparison point: counts and reports a mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Empty model, as after reset.
    task automatic modelReset();
        mq0.delete();
        mq1.delete();
        mLast  = 1'b1;
        mWrv   = 1'b0;
        mWrs   = 1'b0;
        mDir   = 0;
        mDataV = 0;
        mDataS = 8'h00;
    endtask

    // One rising edge of the reference: pick a head by round-robin, present
    // it, then enqueue whatever the requesters offered while not full.
    task automatic modelEdge();
        tbEntry_t e;
        int  g;
        bit  acc0, acc1;
        acc0 = req0_valid && (mq0.size() < TB_DEPTH);
        acc1 = req1_valid && (mq1.size() < TB_DEPTH);
        g = -1;
        if (mq0.size() > 0 && (mq1.size() == 0 || mLast)) g = 0;
        else if (mq1.size() > 0) g = 1;
        if (g == 0) e = mq0.pop_front();
        else if (g == 1) e = mq1.pop_front();
        if (g >= 0) begin
            mLast  = (g == 1);
            mWrv   = e.isVec;
            mWrs   = !e.isVec;
            mDir   = e.dir;
            mDataV = e.data;
            mDataS = e.data[7:0];
        end else begin
            mWrv = 1'b0;
            mWrs = 1'b0;
        end
        if (acc0) mq0.push_back('{req0_is_vec, int'(req0_dir), req0_data});
        if (acc1) mq1.push_back('{req1_is_vec, int'(req1_dir), req1_data});
    endtask

    // Full output comparison against the model's current state.
    task automatic checkAll();
        bit [7:0] pv, ps;
        pv = '0;
        ps = '0;
        foreach (mq0[i]) if (mq0[i].isVec) pv[mq0[i].dir] = 1'b1; else ps[mq0[i].dir] = 1'b1;
        foreach (mq1[i]) if (mq1[i].isVec) pv[mq1[i].dir] = 1'b1; else ps[mq1[i].dir] = 1'b1;
        if (mWrv) pv[mDir] = 1'b1;
        if (mWrs) ps[mDir] = 1'b1;
        checkOutput("ready0",   req0_ready, mq0.size() < TB_DEPTH);
        checkOutput("ready1",   req1_ready, mq1.size() < TB_DEPTH);
        checkOutput("reg_wrv",  reg_wrv,  mWrv);
        checkOutput("reg_wrs",  reg_wrs,  mWrs);
        checkOutput("i_dir_wr", i_dir_wr, mDir);
        checkOutput("data_wrv", data_wrv, mDataV);
        checkOutput("data_wrs", data_wrs, mDataS);
        checkOutput("pend_vec", pend_vec, pv);
        checkOutput("pend_sca", pend_sca, ps);
        checkOutput("strobe_excl", reg_wrv & reg_wrs, 1'b0);
    endtask

    // One clock of stimulus: check at the falling edge, drive new inputs,
    // then advance the model at the rising edge.
    task automatic applyStimulus(input bit v0, input bit iv0, input int d0, input int unsigned dt0,
                                 input bit v1, input bit iv1, input int d1, input int unsigned dt1);
        @(negedge clk);
        checkAll();
        req0_valid  = v0;
        req0_is_vec = iv0;
        req0_dir    = d0[2:0];
        req0_data   = dt0;
        req1_valid  = v1;
        req1_is_vec = iv1;
        req1_dir    = d1[2:0];
        req1_data   = dt1;
        @(posedge clk);
        modelEdge();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic clearInputs();
        req0_valid = 0; req0_is_vec = 0; req0_dir = 0; req0_data = 0;
        req1_valid = 0; req1_is_vec = 0; req1_dir = 0; req1_data = 0;
    endtask

    initial begin
        clearInputs();
        modelReset();
        rst_n = 1'b0;
        #1;
        checkOutput("rst_ready0", req0_ready, 1'b1);
        checkOutput("rst_ready1", req1_ready, 1'b1);
        checkOutput("rst_wrv", reg_wrv, 1'b0);
        checkOutput("rst_pend", {pend_vec, pend_sca}, 16'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        modelEdge();

        // Tie straight after reset: requester 0 first, then 1, next tie -> 0.
        $display("[TB] tie");
        applyStimulus(1, 0, 2, 32'h11, 1, 1, 3, 32'hBEEF_0003);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("tie_first_wrs", reg_wrs, 1'b1);
        checkOutput("tie_first_data", data_wrs, 8'h11);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("tie_second_wrv", reg_wrv, 1'b1);
        checkOutput("tie_second_dir", i_dir_wr, 3'd3);
        applyStimulus(1, 0, 4, 32'h22, 1, 0, 6, 32'h33);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("tie_next_r0", data_wrs, 8'h22);
        idle(3);

        // Single vector write with two-edge latency.
        $display("[TB] single write");
        applyStimulus(1, 1, 5, 32'hA5A5_0001, 0, 0, 0, 0);
        #1;
        checkOutput("sw_pend_early", pend_vec[5], 1'b1);
        checkOutput("sw_wrv_early", reg_wrv, 1'b0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("sw_wrv", reg_wrv, 1'b1);
        checkOutput("sw_dir", i_dir_wr, 3'd5);
        checkOutput("sw_data", data_wrv, 32'hA5A5_0001);
        checkOutput("sw_pend_strobe", pend_vec[5], 1'b1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("sw_wrv_done", reg_wrv, 1'b0);
        checkOutput("sw_pend_clear", pend_vec[5], 1'b0);
        checkOutput("sw_dir_hold", i_dir_wr, 3'd5);
        idle(2);

        // Backpressure with both requesters saturating.
        $display("[TB] backpressure");
        for (int k = 0; k < 16; k++)
            applyStimulus(1, $urandom_range(0, 1), $urandom_range(0, 7), $urandom,
                          1, $urandom_range(0, 1), $urandom_range(0, 7), $urandom);
        idle(6);

        // Ten sequential requester-1 writes; pointers wrap several times.
        $display("[TB] wrap");
        for (int k = 0; k < 10; k++)
            applyStimulus(0, 0, 0, 0, 1, k & 1, k % 8, 32'h1000 + k);
        idle(4);

        // Random traffic.
        $display("[TB] random");
        for (int k = 0; k < 400; k++)
            applyStimulus(($urandom % 4) != 0, $urandom_range(0, 1), $urandom_range(0, 7), $urandom,
                          ($urandom % 3) != 0, $urandom_range(0, 1), $urandom_range(0, 7), $urandom);

        // Fill both FIFOs, then reset between edges.
        $display("[TB] reset mid-operation");
        for (int k = 0; k < 3; k++)
            applyStimulus(1, 1, k, 32'h5000 + k, 1, 0, k + 4, 32'h6000 + k);
        @(negedge clk);
        checkAll();
        #2;
        rst_n = 1'b0;
        clearInputs();
        modelReset();
        #1;
        checkOutput("mid_rst_wrv", reg_wrv, 1'b0);
        checkOutput("mid_rst_wrs", reg_wrs, 1'b0);
        checkOutput("mid_rst_pend_vec", pend_vec, 8'h00);
        checkOutput("mid_rst_pend_sca", pend_sca, 8'h00);
        checkOutput("mid_rst_ready0", req0_ready, 1'b1);
        checkOutput("mid_rst_ready1", req1_ready, 1'b1);
        @(negedge clk);
        rst_n       = 1'b1;
        req0_valid  = 1'b1;
        req0_is_vec = 1'b1;
        req0_dir    = 3'd6;
        req0_data   = 32'h7777_0006;
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput("post_rst_push", pend_vec[6], 1'b1);
        idle(5);

        for (int k = 0; k < 150; k++)
            applyStimulus(($urandom % 2) != 0, $urandom_range(0, 1), $urandom_range(0, 7), $urandom,
                          ($urandom % 2) != 0, $urandom_range(0, 1), $urandom_range(0, 7), $urandom);
        idle(6);
        @(negedge clk);
        checkAll();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
